// File: rtl/tt_um_jakedrew_qei_if.sv
// Pin bundle for the QEI tile: Tiny Tapeout user-module I/O grouped for
// the driving environment (master) and the tile side (slave).
interface tt_um_jakedrew_qei_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in, uio_in, ena,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ui_in, uio_in, ena,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_jakedrew_qei.sv
// Quadrature encoder interface: 2-flop synchronizer on {A,B}, x4 Gray-code
// decode into +1/-1 steps, 16-bit wrapping position counter and direction flag.
module tt_um_jakedrew_qei (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0]  s1_q, s2_q, prev_q;
  logic [15:0] count;
  logic [15:0] count_d;
  logic        dir_q, dir_d;
  logic signed [1:0] step;

  // Map a prev->cur {A,B} transition to a signed step; no change or a
  // double-bit jump yields 0.
  function automatic logic signed [1:0] decode_step(input logic [1:0] prev,
                                                    input logic [1:0] cur);
    logic signed [1:0] s;
    s = 2'sd0;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = 2'sd1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: s = -2'sd1;
      default:                            s = 2'sd0;
    endcase
    return s;
  endfunction

  always_comb begin
    step    = decode_step(prev_q, s2_q);
    count_d = count + {{14{step[1]}}, step};
    dir_d   = dir_q;
    if (step == 2'sd1)       dir_d = 1'b1;
    else if (step == -2'sd1) dir_d = 1'b0;
  end

  // Stage boundary: synchronizer, previous-state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 2'b00;
      s2_q   <= 2'b00;
      prev_q <= 2'b00;
      count  <= 16'h0000;
      dir_q  <= 1'b0;
    end else begin
      s1_q   <= ui_in[1:0];
      s2_q   <= s1_q;
      prev_q <= s2_q;
      count  <= count_d;
      dir_q  <= dir_d;
    end
  end

  assign uo_out  = {dir_q, count[6:0]};
  assign uio_out = count[14:7];
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = ^{ena, uio_in, ui_in[7:2], count[15]};

endmodule

// File: tb/tb_tt_um_jakedrew_qei.sv
// Self-checking bench for tt_um_jakedrew_qei: vector table, directed corner
// sequences and randomized encoder traffic against a phase-index model.
module tb_tt_um_jakedrew_qei;

  logic clk;
  logic rst_n;
  tt_um_jakedrew_qei_if pins ();

  tt_um_jakedrew_qei dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (pins.ena),
    .ui_in   (pins.ui_in),
    .uio_in  (pins.uio_in),
    .uo_out  (pins.uo_out),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: position, direction, last settled {A,B}
  logic [15:0] m_cnt;
  logic        m_dir;
  logic [1:0]  m_ab;

  typedef struct {
    logic [1:0]  ab;
    logic [15:0] exp_cnt;
    logic        exp_dir;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Gray-code position within one electrical cycle, forward order 00,01,11,10
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void model_move(input logic [1:0] ab);
    int d;
    d = (phase(ab) - phase(m_ab) + 4) % 4;
    if (d == 1) begin
      m_cnt = m_cnt + 16'd1;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_cnt = m_cnt - 16'd1;
      m_dir = 1'b0;
    end
    m_ab = ab;
  endfunction

  // Drive a new encoder state just after an edge, hold it, sample on negedge
  task automatic drive(input logic [1:0] ab, input int hold);
    @(posedge clk);
    #1 pins.ui_in = {6'b0, ab};
    repeat (hold) @(posedge clk);
    @(negedge clk);
    model_move(ab);
  endtask

  task automatic check_all(input string name);
    check({name, ".count"}, {16'h0, dut.count}, {16'h0, m_cnt});
    check({name, ".uo_out"}, {24'h0, pins.uo_out}, {24'h0, m_dir, m_cnt[6:0]});
    check({name, ".uio_out"}, {24'h0, pins.uio_out}, {24'h0, m_cnt[14:7]});
  endtask

  task automatic full_cycles(input int n, input bit fwd);
    for (int c = 0; c < n; c++) begin
      if (fwd) begin
        drive(2'b01, 3); drive(2'b11, 3); drive(2'b10, 3); drive(2'b00, 3);
      end else begin
        drive(2'b10, 3); drive(2'b11, 3); drive(2'b01, 3); drive(2'b00, 3);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    logic [14:0] pin0;
    logic [1:0]  ab;

    vecs[0] = '{2'b01, 16'd1, 1'b1};
    vecs[1] = '{2'b11, 16'd2, 1'b1};
    vecs[2] = '{2'b10, 16'd3, 1'b1};
    vecs[3] = '{2'b00, 16'd4, 1'b1};
    vecs[4] = '{2'b10, 16'd3, 1'b0};
    vecs[5] = '{2'b11, 16'd2, 1'b0};
    vecs[6] = '{2'b01, 16'd1, 1'b0};
    vecs[7] = '{2'b00, 16'd0, 1'b0};

    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    pins.ena    = 1'b1;
    rst_n       = 1'b0;
    m_cnt = 16'h0; m_dir = 1'b0; m_ab = 2'b00;

    // Reset and idle
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("reset.uo_out", {24'h0, pins.uo_out}, 32'h00);
    check("reset.uio_out", {24'h0, pins.uio_out}, 32'h00);
    check("reset.uio_oe", {24'h0, pins.uio_oe}, 32'hFF);
    check("reset.count", {16'h0, dut.count}, 32'h0);

    // Single forward then backward steps, 8-clock holds
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].ab, 8);
      check($sformatf("vec%0d.count", i), {16'h0, dut.count}, {16'h0, vecs[i].exp_cnt});
      check($sformatf("vec%0d.uo_out", i), {24'h0, pins.uo_out},
            {24'h0, vecs[i].exp_dir, vecs[i].exp_cnt[6:0]});
    end

    // Multi-cycle forward / backward with pin-level deltas
    full_cycles(8, 1'b1);
    check("fwd8.count", {16'h0, dut.count}, 32'd32);
    check("fwd8.low7", {25'h0, pins.uo_out[6:0]}, 32'd32);
    pin0 = {pins.uio_out, pins.uo_out[6:0]};
    full_cycles(64, 1'b1);
    check("fwd64.count", {16'h0, dut.count}, 32'd288);
    check("fwd64.pins", {17'h0, pins.uio_out, pins.uo_out[6:0]}, {17'h0, pin0 + 15'd256});
    pin0 = {pins.uio_out, pins.uo_out[6:0]};
    full_cycles(64, 1'b0);
    check("bwd64.count", {16'h0, dut.count}, 32'd32);
    check("bwd64.pins", {17'h0, pins.uio_out, pins.uo_out[6:0]}, {17'h0, pin0 - 15'd256});
    check("bwd64.dir", {31'h0, pins.uo_out[7]}, 32'd0);
    full_cycles(8, 1'b0);
    check("bwd8.count", {16'h0, dut.count}, 32'd0);

    // Wrap below zero and back
    drive(2'b10, 4);
    check("wrap.count", {16'h0, dut.count}, 32'hFFFF);
    check("wrap.uio_out", {24'h0, pins.uio_out}, 32'hFF);
    check("wrap.uo_out", {24'h0, pins.uo_out}, 32'h7F);
    drive(2'b00, 4);
    check("unwrap.count", {16'h0, dut.count}, 32'h0);
    check("unwrap.dir", {31'h0, pins.uo_out[7]}, 32'd1);

    // Illegal double-bit jumps hold count and dir
    drive(2'b01, 4); check_all("ill.pre");
    drive(2'b10, 4); check_all("ill.01to10");
    check("ill.01to10.cnt", {16'h0, dut.count}, 32'd1);
    drive(2'b01, 4); check_all("ill.10to01");
    drive(2'b00, 4); check_all("ill.back");
    drive(2'b11, 4); check_all("ill.00to11");
    check("ill.00to11.cnt", {16'h0, dut.count}, 32'd0);
    drive(2'b00, 4); check_all("ill.11to00");

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      ab = 2'($urandom_range(0, 3));
      drive(ab, int'($urandom_range(3, 6)));
      check_all($sformatf("rnd%0d", i));
    end

    // Async reset mid-count, then release with A/B already at 01
    full_cycles(3, 1'b1);
    drive(2'b01, 4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset.uo_out", {24'h0, pins.uo_out}, 32'h00);
    check("areset.uio_out", {24'h0, pins.uio_out}, 32'h00);
    check("areset.count", {16'h0, dut.count}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_cnt = 16'h0; m_dir = 1'b0; m_ab = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    model_move(2'b01);
    check_all("release01");
    check("release01.cnt", {16'h0, dut.count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
